// File: rtl/ipml_fifo_rd_stream_fft_fifo.sv
// Read-side stream adapter for the FFT FIFO: issues reads against a credit
// budget, lands RAM data in a skid buffer and emits it as a framed stream.
module ipml_fifo_rd_stream_fft_fifo #(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_RD_LATENCY = 1,
  parameter int c_FRAME_LEN  = 1024,
  parameter int c_BUF_DEPTH  = c_RD_LATENCY + 2,
  localparam int c_LVL_W     = $clog2(c_BUF_DEPTH) + 1
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic                    rempty,
  output logic                    r_en,
  input  logic [c_DATA_WIDTH-1:0] rdata,
  input  logic                    flush,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [c_DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic [15:0]             frame_cnt,
  output logic [c_LVL_W-1:0]      buf_level
);

  localparam int PW = $clog2(c_BUF_DEPTH);
  localparam int IW = $clog2(c_FRAME_LEN);

  logic [c_DATA_WIDTH-1:0] mem [c_BUF_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [c_RD_LATENCY-1:0] pend;
  logic [IW-1:0]           idx;
  logic [c_LVL_W-1:0]      inflight;
  logic                    push;
  logic                    pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(c_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < c_RD_LATENCY; i++)
      inflight = inflight + c_LVL_W'(pend[i]);
  end

  // Credits cover both landed and still-in-flight words, so the buffer
  // can never overflow regardless of downstream backpressure.
  assign r_en = !rrst && !rempty && !flush &&
                ((inflight + buf_level) < c_LVL_W'(c_BUF_DEPTH));

  assign m_valid = (buf_level != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign m_last  = m_valid && (idx == IW'(c_FRAME_LEN - 1));
  assign push    = pend[c_RD_LATENCY-1] && !flush;
  assign pop     = m_valid && m_ready && !flush;

  always_ff @(posedge rclk) begin
    if (push)
      mem[wr_ptr] <= rdata;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      pend      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_level <= '0;
      idx       <= '0;
      frame_cnt <= '0;
    end else if (flush) begin
      pend      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_level <= '0;
      idx       <= '0;
    end else begin
      pend <= c_RD_LATENCY'({pend, r_en});
      if (push)
        wr_ptr <= nxt(wr_ptr);
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
        if (m_last) begin
          idx       <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (push && !pop)
        buf_level <= buf_level + 1'b1;
      else if (pop && !push)
        buf_level <= buf_level - 1'b1;
    end
  end

endmodule

// File: tb/tb_ipml_fifo_rd_stream_fft_fifo.sv
// Scoreboard bench: FIFO/RAM model feeds the DUT, a negedge monitor
// compares every stream transfer against the expected-word queue.
module tb_ipml_fifo_rd_stream_fft_fifo;

  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int FL  = 4;
  localparam int BD  = LAT + 2;
  localparam int LVW = $clog2(BD) + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic           rclk = 1'b0;
  logic           rrst = 1'b1;
  logic           rempty = 1'b1;
  logic           r_en;
  logic [DW-1:0]  rdata;
  logic           flush = 1'b0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [DW-1:0]  m_data;
  logic           m_last;
  logic [15:0]    frame_cnt;
  logic [LVW-1:0] buf_level;

  int             errors = 0;
  int             checks = 0;
  int             wr_idx = 0;
  int             max_lvl = 0;
  exp_t           exp_q[$];
  logic [DW-1:0]  fifo_q[$];
  logic [DW-1:0]  pipe [LAT];
  logic           hold_prev = 1'b0;
  logic [DW-1:0]  prev_data = '0;

  ipml_fifo_rd_stream_fft_fifo #(
    .c_DATA_WIDTH(DW),
    .c_RD_LATENCY(LAT),
    .c_FRAME_LEN (FL)
  ) u_dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rempty   (rempty),
    .r_en     (r_en),
    .rdata    (rdata),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .frame_cnt(frame_cnt),
    .buf_level(buf_level)
  );

  always #5 rclk = ~rclk;

  // FIFO controller + RAM model with registered empty flag
  assign rdata = pipe[LAT-1];

  always @(posedge rclk or posedge rrst) begin
    logic [DW-1:0] d;
    if (rrst) begin
      fifo_q.delete();
      rempty <= 1'b1;
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      d = '0;
      if (r_en && fifo_q.size() != 0) d = fifo_q.pop_front();
      pipe[0] <= d;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      rempty <= (fifo_q.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(negedge rclk) begin
    exp_t e;
    if (rrst) begin
      hold_prev = 1'b0;
    end else begin
      chk("r_en_while_empty", DW'(r_en && rempty), '0);
      if (int'(buf_level) > max_lvl) max_lvl = int'(buf_level);
      if (hold_prev) begin
        chk("hold_valid", DW'(m_valid), 1);
        chk("hold_data", m_data, prev_data);
      end
      hold_prev = m_valid && !m_ready && !flush;
      prev_data = m_data;
      if (m_valid && m_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", m_data, '1);
        end else begin
          e = exp_q.pop_front();
          chk("data", m_data, e.d);
          chk("last", DW'(m_last), DW'(e.l));
        end
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      e.d = base + DW'(i);
      e.l = (wr_idx == FL - 1);
      exp_q.push_back(e);
      wr_idx = (wr_idx + 1) % FL;
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_left", DW'(exp_q.size()), '0);
  endtask

  initial begin
    int te, tv, lv, nv, n;
    logic [3:0] pat;

    #3;
    chk("rst_r_en", DW'(r_en), 0);
    chk("rst_m_valid", DW'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", DW'(m_last), 0);
    chk("rst_frame_cnt", DW'(frame_cnt), 0);
    chk("rst_buf_level", DW'(buf_level), 0);
    tick();
    tick();
    rrst = 1'b0;

    // latency and back-to-back throughput
    m_ready = 1'b1;
    push_words(8, 32'h0);
    te = -1; tv = -1; lv = -1; nv = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (!rempty && te < 0) te = c;
      if (m_valid) begin
        nv++;
        if (tv < 0) tv = c;
        lv = c;
      end
    end
    chk("first_latency", DW'(tv - te), LAT + 1);
    chk("valid_cycles", DW'(nv), 8);
    chk("valid_span", DW'(lv - tv), 7);
    drain(10);
    chk("frames_a", DW'(frame_cnt), 2);

    // frame boundaries
    push_words(12, 32'h100);
    drain(60);
    chk("frames_b", DW'(frame_cnt), 5);

    // backpressure pattern 1-0-0-1
    pat = 4'b1001;
    push_words(64, 32'h1000);
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      m_ready = pat[n % 4];
      tick();
      n++;
    end
    m_ready = 1'b1;
    chk("bp_drain_left", DW'(exp_q.size()), 0);
    chk("frames_c", DW'(frame_cnt), 21);

    // flush with 3 buffered, 1 in flight
    m_ready = 1'b0;
    push_words(4, 32'h2000);
    n = 0;
    while (buf_level != LVW'(3) && n < 20) begin
      tick();
      n++;
    end
    chk("pre_flush_level", DW'(buf_level), 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", DW'(m_valid), 0);
    chk("flush_level", DW'(buf_level), 0);
    exp_q.delete();
    wr_idx = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flush_no_leak", DW'(m_valid), 0);
    end
    chk("flush_frames_kept", DW'(frame_cnt), 21);
    push_words(8, 32'h3000);
    drain(40);
    chk("frames_d", DW'(frame_cnt), 23);

    // async reset mid-frame
    push_words(6, 32'h4000);
    n = 0;
    while (exp_q.size() > 4 && n < 30) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    tick();
    chk("pre_rst_valid", DW'(m_valid), 1);
    #3;
    rrst = 1'b1;
    #1;
    chk("arst_r_en", DW'(r_en), 0);
    chk("arst_m_valid", DW'(m_valid), 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_m_last", DW'(m_last), 0);
    chk("arst_frame_cnt", DW'(frame_cnt), 0);
    chk("arst_buf_level", DW'(buf_level), 0);
    exp_q.delete();
    wr_idx = 0;
    tick();
    tick();
    rrst = 1'b0;
    m_ready = 1'b1;
    push_words(4, 32'h5000);
    drain(30);
    chk("frames_e", DW'(frame_cnt), 1);

    // idle with empty FIFO
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_r_en", DW'(r_en), 0);
      chk("idle_m_valid", DW'(m_valid), 0);
    end

    chk("max_level_ok", DW'(max_lvl <= BD), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ipml_fifo_rd_stream_fft_fifo.md
Name: ipml_fifo_rd_stream_fft_fifo

Overview:
- Read-side consumer for the FFT FIFO controller and RAM. It drives `r_en`, captures RAM read data after the fixed RAM read latency, and presents the data as a valid/ready stream with a frame-boundary `m_last`.
- Sits in the read clock domain, between the FIFO (controller plus RAM) and the FFT input stage.
- An internal skid buffer sustains one word per clock under continuous `m_ready` and absorbs backpressure without losing in-flight reads.

Parameters:
- c_DATA_WIDTH, 32, width of RAM read data and stream data.
- c_RD_LATENCY, 1, clocks from `r_en` high to matching `rdata` valid; legal 1..3.
- c_FRAME_LEN, 1024, words per frame; `m_last` marks the last word; legal 2..65536.
- c_BUF_DEPTH, c_RD_LATENCY+2, skid buffer entries (derived; do not override).

Ports:
- rclk  in  1  read clock, the only clock.
- rrst  in  1  asynchronous active-high reset.
- rempty  in  1  FIFO empty flag (registered in the controller).
- r_en  out  1  read request to the FIFO controller.
- rdata  in  c_DATA_WIDTH  RAM read data, valid c_RD_LATENCY clocks after `r_en`.
- flush  in  1  synchronous flush: discard buffered and in-flight words, restart the frame count.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_data  out  c_DATA_WIDTH  stream data.
- m_last  out  1  high with the last word of each frame.
- frame_cnt  out  16  completed frames, wraps at 65535.
- buf_level  out  clog2(c_BUF_DEPTH)+1  current skid buffer occupancy.

Behaviour:

Reset (`rrst` high, async):
- `r_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `frame_cnt`=0, `buf_level`=0.
- In-flight tracking is cleared; the word index is 0.

Read issue:
- `r_en` = !rempty && !flush && (inflight + buf_level < c_BUF_DEPTH). It is combinational from registered state plus `rempty`.
- `r_en` is never asserted while `rempty`=1.
- `rempty` reflects all reads up to the previous clock, so back-to-back `r_en` is legal while `rempty`=0.

In-flight tracking:
- Shift register of width c_RD_LATENCY.
- Bit 0 loads `r_en`. When bit c_RD_LATENCY-1 is set, `rdata` on that clock is written into the buffer.
- inflight = popcount of the shift register.

Skid buffer:
- Circular buffer with c_BUF_DEPTH entries, write and read pointers, and an occupancy counter.
- Write and read in the same clock: occupancy is unchanged.
- Overflow cannot occur because of the credit rule. The bench must assert this.

Stream output:
- `m_valid` = (buf_level != 0). `m_data` is the buffer head (registered storage, no combinational path from `rdata`).
- A transfer happens when `m_valid` && `m_ready`.
- `m_valid` and `m_data` stay stable until the transfer.
- First-word latency: `rempty` falls at clock t → `r_en` at t → `m_valid` at t+c_RD_LATENCY+1.
- Throughput with `m_ready`=1 held is one word per clock.

Frame counting:
- Word index counts 0..c_FRAME_LEN-1 and advances on each transfer.
- `m_last` = m_valid && (index == c_FRAME_LEN-1).
- On a transfer with `m_last`=1: index → 0 and `frame_cnt` increments, wrapping 65535 → 0.

Flush (sampled at rclk):
- Next clock: `buf_level`=0, `m_valid`=0, index=0, in-flight shift register cleared. Data returning from reads issued before the flush is dropped.
- `r_en`=0 during the flush clock. `frame_cnt` is not cleared.
- A transfer coinciding with flush is not counted.

Backpressure:
- `m_ready`=0 with the buffer full: `r_en` stays 0 until a transfer frees a credit; `r_en` may rise on the same clock as that transfer's next state.

FIFO drains mid-frame:
- `m_valid` drops after the last buffered word. The index is kept, and the frame resumes when data returns.

Test Plan:
1. c_RD_LATENCY=1. Reset, then 8 words written (0x0..0x7), `m_ready`=1 → first `m_valid` 2 clocks after `rempty` falls; 8 consecutive transfers; data 0..7 in order; `r_en` never high while `rempty`=1.
2. c_RD_LATENCY=3, `m_ready` toggling 1-0-0-1 over 64 words → no loss or duplication; `buf_level` never exceeds 5; `m_data` stable whenever `m_valid` && !`m_ready`.
3. c_FRAME_LEN=4, 12 words streamed → `m_last` on words 3, 7, 11; `frame_cnt` reads 3.
4. Flush asserted with 3 words buffered and 1 in flight → next clock `m_valid`=0 and `buf_level`=0; the in-flight word is never output; the following word is treated as index 0 (`m_last` on the 4th word after).
5. `rrst` pulsed mid-frame while `m_valid`=1 → all outputs 0 immediately (asynchronously); after release, streaming resumes with `frame_cnt`=0.
6. Idle: FIFO empty, `m_ready`=1 for 100 clocks → `r_en`=0 and `m_valid`=0 throughout.
